epidemic_ni: RTL and testbench

- Network interface for one grid node's local port, sitting between the host/traffic source and the node's router.
- Injection path:
  - accepts host payloads
  - stamps a single-flit epidemic header (dst, src, sequence number, TTL)
  - buffers packets in a FIFO
  - drives the node's ready/valid/data input
- Ejection path:
  - consumes flooded flits from the node
  - discards flits addressed to other nodes and duplicate copies
  - presents each unique packet once to the host

---
 rtl/epidemic_ni.sv | 227 ++++++++++++++++++++++
 tb/tb_epidemic_ni.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/epidemic_ni.sv
// epidemic_ni - network interface for one grid node's local port.
//
// Injection: host packets are stamped with a single-flit epidemic header
// {dst_x, dst_y, src_x, src_y, seq, ttl} and queued in a small FIFO that
// drives the node's local input. Out-of-grid destinations are discarded
// and flagged on the sticky err_dst output.
// Ejection: flooded flits from the node are filtered. Flits addressed to
// other nodes are dropped. Copies whose (src, seq) is still in a small
// FIFO-replaced "seen" table are also dropped. Each remaining packet is
// presented once to the host through a single output register.
//
// Ports
//   clk, rstn                        clock, synchronous active-high reset
//   h_valid/h_ready/h_dst_*/h_data   host injection handshake
//   o_valid_n/i_ready_n/o_data_n     flit stream toward the node
//   i_valid_n/o_ready_n/i_data_n     flit stream from the node
//   d_valid/d_ready/d_data/d_src_*   unique delivery toward the host
//   err_dst                          sticky out-of-grid destination flag
//   st_inj/st_del/st_dup             saturating statistics counters
//
// Build option: define EPI_NI_STATS_EN to build the statistics counters.
// Without it, st_inj/st_del/st_dup are tied to zero.
module epidemic_ni #(
  parameter int X        = 4,
  parameter int Y        = 4,
  parameter int MY_X     = 0,
  parameter int MY_Y     = 0,
  parameter int COORD_W  = 2,
  parameter int DATA_W   = 32,
  parameter int SEQ_W    = 8,
  parameter int TTL_W    = 4,
  parameter int TTL_INIT = 6,
  parameter int DEPTH    = 4,
  parameter int SEEN     = 8,
  localparam int PKT_W   = 4*COORD_W + SEQ_W + TTL_W + DATA_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               h_valid,
  output logic               h_ready,
  input  logic [COORD_W-1:0] h_dst_x,
  input  logic [COORD_W-1:0] h_dst_y,
  input  logic [DATA_W-1:0]  h_data,
  output logic               o_valid_n,
  input  logic               i_ready_n,
  output logic [PKT_W-1:0]   o_data_n,
  input  logic               i_valid_n,
  output logic               o_ready_n,
  input  logic [PKT_W-1:0]   i_data_n,
  output logic               d_valid,
  input  logic               d_ready,
  output logic [DATA_W-1:0]  d_data,
  output logic [COORD_W-1:0] d_src_x,
  output logic [COORD_W-1:0] d_src_y,
  output logic               err_dst,
  output logic [15:0]        st_inj,
  output logic [15:0]        st_del,
  output logic [15:0]        st_dup
);

  localparam int AW     = $clog2(DEPTH);
  localparam int SPW    = $clog2(SEEN);
  localparam int KEY_W  = 2*COORD_W + SEQ_W;
  localparam int LO_SEQ = DATA_W + TTL_W;
  localparam int LO_SY  = LO_SEQ + SEQ_W;
  localparam int LO_DY  = LO_SY + 2*COORD_W;
  localparam int LO_DX  = LO_DY + COORD_W;

  localparam logic [COORD_W-1:0] MY_XC    = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_YC    = COORD_W'(MY_Y);
  localparam logic [COORD_W:0]   X_LIM    = (COORD_W+1)'(X);
  localparam logic [COORD_W:0]   Y_LIM    = (COORD_W+1)'(Y);
  localparam logic [AW:0]        FULL_CNT = (AW+1)'(DEPTH);

  // ---------------- injection path ----------------
  logic [PKT_W-1:0]   fifo_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic               err_q, err_d;
  logic               h_xfer, dst_ok, push, pop;
  logic [PKT_W-1:0]   inj_flit;

  assign h_ready   = (cnt_q != FULL_CNT);
  assign o_valid_n = (cnt_q != '0);
  assign o_data_n  = fifo_q[rd_ptr_q];
  assign h_xfer    = h_valid & h_ready;
  assign dst_ok    = ({1'b0, h_dst_x} < X_LIM) && ({1'b0, h_dst_y} < Y_LIM);
  assign push      = h_xfer & dst_ok;
  assign pop       = o_valid_n & i_ready_n;
  assign inj_flit  = {h_dst_x, h_dst_y, MY_XC, MY_YC, seq_q, TTL_W'(TTL_INIT), h_data};
  assign err_dst   = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    err_d    = err_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      seq_d    = seq_q + SEQ_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (h_xfer && !dst_ok) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      seq_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
      err_q    <= err_d;
    end
  end

  // A push coinciding with reset must not land in the queue.
  always_ff @(posedge clk) begin
    if (push && !rstn) fifo_q[wr_ptr_q] <= inj_flit;
  end

  // ---------------- ejection path ----------------
  logic [KEY_W-1:0]   seen_key_q [SEEN];
  logic [SEEN-1:0]    seen_vld_q;
  logic [SPW-1:0]     rep_ptr_q;
  logic               d_valid_q, d_valid_d;
  logic [DATA_W-1:0]  d_data_q;
  logic [2*COORD_W-1:0] d_src_q;
  logic [KEY_W-1:0]   ej_key;
  logic [TTL_W-1:0]   unused_ttl;
  logic               dup_hit, ej_acc, ej_me, ej_new, ej_dup, d_drain;

  assign ej_key     = i_data_n[LO_SEQ +: KEY_W];   // {src_x, src_y, seq}
  assign unused_ttl = i_data_n[DATA_W +: TTL_W];   // router owns TTL
  assign ej_me      = (i_data_n[LO_DX +: COORD_W] == MY_XC) &&
                      (i_data_n[LO_DY +: COORD_W] == MY_YC);
  assign o_ready_n  = !d_valid_q | d_ready;
  assign ej_acc     = i_valid_n & o_ready_n;
  assign ej_new     = ej_acc & ej_me & !dup_hit;
  assign ej_dup     = ej_acc & ej_me & dup_hit;
  assign d_drain    = d_valid_q & d_ready;

  assign d_valid = d_valid_q;
  assign d_data  = d_data_q;
  assign d_src_x = d_src_q[2*COORD_W-1:COORD_W];
  assign d_src_y = d_src_q[COORD_W-1:0];

  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < SEEN; i++) begin
      if (seen_vld_q[i] && (seen_key_q[i] == ej_key)) dup_hit = 1'b1;
    end
  end

  // New packet loading wins over a same-cycle drain.
  always_comb begin
    d_valid_d = d_valid_q;
    if (d_drain) d_valid_d = 1'b0;
    if (ej_new)  d_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      d_valid_q  <= 1'b0;
      seen_vld_q <= '0;
      rep_ptr_q  <= '0;
    end else begin
      d_valid_q <= d_valid_d;
      if (ej_new) begin
        seen_vld_q[rep_ptr_q] <= 1'b1;
        rep_ptr_q             <= rep_ptr_q + SPW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ej_new) begin
      d_data_q              <= i_data_n[DATA_W-1:0];
      d_src_q               <= i_data_n[LO_SY +: 2*COORD_W];
      seen_key_q[rep_ptr_q] <= ej_key;
    end
  end

  // ---------------- statistics ----------------
`ifdef EPI_NI_STATS_EN
  logic [15:0] st_inj_q, st_del_q, st_dup_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rstn) begin
      st_inj_q <= '0;
      st_del_q <= '0;
      st_dup_q <= '0;
    end else begin
      st_inj_q <= sat_inc(st_inj_q, pop);
      st_del_q <= sat_inc(st_del_q, d_drain);
      st_dup_q <= sat_inc(st_dup_q, ej_dup);
    end
  end

  assign st_inj = st_inj_q;
  assign st_del = st_del_q;
  assign st_dup = st_dup_q;
`else
  logic unused_stats;
  assign unused_stats = ej_dup ^ d_drain;
  assign st_inj = '0;
  assign st_del = '0;
  assign st_dup = '0;
`endif

endmodule

// File: tb/tb_epidemic_ni.sv
module tb_epidemic_ni;
  localparam int X = 4, Y = 4, MX = 0, MY = 0;
  localparam int CW = 3, DW = 32, SW = 8, TW = 4, TTL_INIT = 6;
  localparam int DEPTH = 4, SEEN = 8;
  localparam int PW = 4*CW + SW + TW + DW;
`ifdef EPI_NI_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, h_valid, h_ready, o_valid_n, i_ready_n, i_valid_n, o_ready_n;
  logic          d_valid, d_ready, err_dst;
  logic [CW-1:0] h_dst_x, h_dst_y, d_src_x, d_src_y;
  logic [DW-1:0] h_data, d_data;
  logic [PW-1:0] o_data_n, i_data_n;
  logic [15:0]   st_inj, st_del, st_dup;

  epidemic_ni #(.X(X), .Y(Y), .MY_X(MX), .MY_Y(MY), .COORD_W(CW), .DATA_W(DW),
                .SEQ_W(SW), .TTL_W(TW), .TTL_INIT(TTL_INIT), .DEPTH(DEPTH), .SEEN(SEEN))
  dut (
    .clk(clk), .rstn(rstn), .h_valid(h_valid), .h_ready(h_ready),
    .h_dst_x(h_dst_x), .h_dst_y(h_dst_y), .h_data(h_data),
    .o_valid_n(o_valid_n), .i_ready_n(i_ready_n), .o_data_n(o_data_n),
    .i_valid_n(i_valid_n), .o_ready_n(o_ready_n), .i_data_n(i_data_n),
    .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
    .d_src_x(d_src_x), .d_src_y(d_src_y), .err_dst(err_dst),
    .st_inj(st_inj), .st_del(st_del), .st_dup(st_dup)
  );

  int ncmp = 0, nfail = 0;

  // Reference model: queued flits, seen-key history, delivery slot, counters.
  logic [PW-1:0]       fq[$];
  logic [2*CW+SW-1:0]  seen[$];
  int                  m_seq, m_inj, m_del, m_dup;
  bit                  m_err, m_dv;
  logic [DW-1:0]       m_dd;
  logic [CW-1:0]       m_dsx, m_dsy;

  function automatic logic [PW-1:0] mkflit(int dx, int dy, int sx, int sy, int sq, int tt,
                                            logic [DW-1:0] d);
    return {CW'(dx), CW'(dy), CW'(sx), CW'(sy), SW'(sq), TW'(tt), d};
  endfunction

  function automatic int seq_of(logic [PW-1:0] f);
    return int'(f[DW+TW +: SW]);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete(); seen.delete();
    m_seq = 0; m_inj = 0; m_del = 0; m_dup = 0;
    m_err = 0; m_dv = 0;
  endtask

  // One clock: compare outputs at the falling edge, then apply the rules at the rising edge.
  task automatic cycle();
    bit hx, hok, pop, acc, drain, me, hit;
    int hdx, hdy;
    logic [DW-1:0] hd;
    logic [PW-1:0] f;
    logic [2*CW+SW-1:0] k;
    @(negedge clk);
    chk("h_ready", 64'(h_ready), 64'(fq.size() < DEPTH));
    chk("o_valid_n", 64'(o_valid_n), 64'(fq.size() != 0));
    if (fq.size() != 0) chk("o_data_n", 64'(o_data_n), 64'(fq[0]));
    chk("o_ready_n", 64'(o_ready_n), 64'(!m_dv || d_ready));
    chk("d_valid", 64'(d_valid), 64'(m_dv));
    if (m_dv) begin
      chk("d_data", 64'(d_data), 64'(m_dd));
      chk("d_src", 64'({d_src_x, d_src_y}), 64'({m_dsx, m_dsy}));
    end
    chk("err_dst", 64'(err_dst), 64'(m_err));
    chk("st_inj", 64'(st_inj), STATS ? 64'(m_inj) : 64'd0);
    chk("st_del", 64'(st_del), STATS ? 64'(m_del) : 64'd0);
    chk("st_dup", 64'(st_dup), STATS ? 64'(m_dup) : 64'd0);
    hdx = int'(h_dst_x); hdy = int'(h_dst_y); hd = h_data;
    hx    = h_valid && (fq.size() < DEPTH);
    hok   = (hdx < X) && (hdy < Y);
    pop   = (fq.size() != 0) && i_ready_n;
    acc   = i_valid_n && (!m_dv || d_ready);
    drain = m_dv && d_ready;
    f     = i_data_n;
    me    = (int'(f[PW-1 -: CW]) == MX) && (int'(f[PW-CW-1 -: CW]) == MY);
    k     = f[DW+TW +: 2*CW+SW];
    @(posedge clk);
    if (rstn) model_reset();
    else begin
      if (pop) begin void'(fq.pop_front()); if (m_inj < 65535) m_inj++; end
      if (hx) begin
        if (hok) begin
          fq.push_back(mkflit(hdx, hdy, MX, MY, m_seq, TTL_INIT, hd));
          m_seq = (m_seq + 1) % (1 << SW);
        end else m_err = 1;
      end
      if (drain) begin m_dv = 0; if (m_del < 65535) m_del++; end
      if (acc && me) begin
        hit = 0;
        foreach (seen[i]) if (seen[i] == k) hit = 1;
        if (hit) begin if (m_dup < 65535) m_dup++; end
        else begin
          m_dv = 1; m_dd = f[DW-1:0];
          m_dsx = f[DW+TW+SW+CW +: CW]; m_dsy = f[DW+TW+SW +: CW];
          seen.push_back(k);
          if (seen.size() > SEEN) void'(seen.pop_front());
        end
      end
    end
    #1;
  endtask

  task automatic host(int dx, int dy, logic [DW-1:0] d);
    h_valid = 1; h_dst_x = CW'(dx); h_dst_y = CW'(dy); h_data = d;
  endtask

  task automatic do_reset();
    rstn = 1; cycle(); rstn = 0;
  endtask

  logic [PW-1:0] t;

  initial begin
    rstn = 1; h_valid = 0; h_dst_x = '0; h_dst_y = '0; h_data = '0;
    i_ready_n = 0; i_valid_n = 0; i_data_n = '0; d_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_h_ready", 64'(h_ready), 64'd1);
    chk("rst_o_valid_n", 64'(o_valid_n), 64'd0);
    chk("rst_o_ready_n", 64'(o_ready_n), 64'd1);
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    cycle();
    rstn = 0;

    // Header stamping, one-cycle latency, sequence increment
    i_ready_n = 1;
    host(1, 2, 32'hA5A5A5A5); cycle();
    chk("tp1_flit0", 64'(o_data_n), 64'(mkflit(1, 2, 0, 0, 0, 6, 32'hA5A5A5A5)));
    chk("tp1_valid0", 64'(o_valid_n), 64'd1);
    host(3, 1, 32'h12345678); cycle();
    chk("tp1_flit1", 64'(o_data_n), 64'(mkflit(3, 1, 0, 0, 1, 6, 32'h12345678)));
    h_valid = 0; cycle();
    chk("tp1_drained", 64'(o_valid_n), 64'd0);

    // Backpressure fills the FIFO, then flits leave in order
    do_reset();
    i_ready_n = 0;
    for (int i = 0; i < 5; i++) begin host(i % 4, 2, 32'(100 + i)); cycle(); end
    chk("tp2_full", 64'(h_ready), 64'd0);
    h_valid = 0; i_ready_n = 1;
    for (int i = 0; i < 4; i++) begin
      t = o_data_n;
      chk("tp2_seq", 64'(seq_of(t)), 64'(i));
      cycle();
    end
    chk("tp2_empty", 64'(o_valid_n), 64'd0);

    // Duplicate on the very next cycle
    d_ready = 1; i_valid_n = 1; i_data_n = mkflit(0, 0, 3, 3, 7, 2, 32'hDEAD0007);
    cycle();
    chk("tp3_first", 64'(d_valid), 64'd1);
    chk("tp3_data", 64'(d_data), 64'hDEAD0007);
    cycle();
    chk("tp3_dup_gone", 64'(d_valid), 64'd0);
    chk("tp3_st_dup", 64'(st_dup), STATS ? 64'd1 : 64'd0);

    // Nine unique sequence numbers evict seq 0
    for (int i = 0; i < 9; i++) begin
      i_data_n = mkflit(0, 0, 1, 1, i, 5, 32'(32'hB000 + i)); cycle();
    end
    i_data_n = mkflit(0, 0, 1, 1, 0, 5, 32'hB0FF); cycle();
    chk("tp4_reaccept", 64'(d_valid), 64'd1);
    chk("tp4_data", 64'(d_data), 64'hB0FF);

    // Foreign flit dropped; out-of-grid host destination flagged
    i_valid_n = 0; cycle();
    d_ready = 0; i_valid_n = 1; i_data_n = mkflit(2, 1, 3, 0, 4, 1, 32'hC0C0); cycle();
    chk("tp5_no_dv", 64'(d_valid), 64'd0);
    chk("tp5_ready", 64'(o_ready_n), 64'd1);
    i_valid_n = 0; i_ready_n = 0;
    host(4, 0, 32'hBAD); cycle();
    chk("tp5_err", 64'(err_dst), 64'd1);
    chk("tp5_no_flit", 64'(o_valid_n), 64'd0);
    h_valid = 0; cycle();
    chk("tp5_sticky", 64'(err_dst), 64'd1);

    // Reset with a pending delivery and a partly full FIFO
    for (int i = 0; i < 3; i++) begin host(1, 1, 32'(i)); cycle(); end
    h_valid = 0; i_valid_n = 1; i_data_n = mkflit(0, 0, 2, 2, 9, 3, 32'h9999); cycle();
    chk("tp6_dv", 64'(d_valid), 64'd1);
    rstn = 1; host(2, 2, 32'h77); i_data_n = mkflit(0, 0, 2, 3, 1, 3, 32'h88); cycle();
    rstn = 0; h_valid = 0; i_valid_n = 0;
    chk("tp6_rst_dv", 64'(d_valid), 64'd0);
    chk("tp6_rst_ov", 64'(o_valid_n), 64'd0);
    chk("tp6_rst_err", 64'(err_dst), 64'd0);
    host(1, 3, 32'h55); cycle();
    h_valid = 0;
    t = o_data_n;
    chk("tp6_seq0", 64'(seq_of(t)), 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rstn      = ($urandom_range(0, 249) == 0);
      h_valid   = $urandom_range(0, 1);
      h_dst_x   = CW'($urandom_range(0, 4));
      h_dst_y   = CW'($urandom_range(0, 4));
      h_data    = $urandom;
      i_ready_n = ($urandom_range(0, 9) < 6);
      i_valid_n = $urandom_range(0, 1);
      d_ready   = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 7)
        i_data_n = mkflit(MX, MY, $urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom_range(0, 5), $urandom_range(0, 15), $urandom);
      else
        i_data_n = mkflit($urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 5), 0, $urandom);
      cycle();
    end
    rstn = 0; h_valid = 0; i_valid_n = 0; i_ready_n = 1; d_ready = 1;
    repeat (6) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
